// File: rtl/eth_tx_scheduler_pkg.sv
// Shared types and constants for the Ethernet TX scheduler and its preamble/SFD generator.
package eth_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREAMBLE = 2'd1,
        S_PAYLOAD  = 2'd2,
        S_IFG      = 2'd3
    } state_t;

    localparam int unsigned IFG_CYC_DEF       = 12;
    localparam int unsigned PRE_TIMEOUT_DEF   = 15;
    localparam int unsigned MAX_FRAME_CYC_DEF = 1530;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

endpackage

// File: rtl/eth_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after i_ptr, wrapping.
module eth_tx_scheduler_rr_arbiter
    import eth_tx_scheduler_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [PTR_W-1:0] o_idx
);

    logic [PTR_W-1:0] w_idx;

    always_comb begin
        o_grant = '0;
        o_idx   = i_ptr;
        w_idx   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            w_idx = PTR_W'((32'(i_ptr) + k) % N_REQ);
            if (o_grant == '0 && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_idx          = w_idx;
            end
        end
    end

endmodule

// File: rtl/eth_tx_scheduler.sv
// Shares the Ethernet TX path between N_REQ sources: preamble, payload, IFG sequencing
// with round-robin grant and a watchdog that aborts stalled frames.
module eth_tx_scheduler
    import eth_tx_scheduler_pkg::*;
#(
    parameter int unsigned N_REQ         = 2,
    parameter int unsigned IFG_CYC       = IFG_CYC_DEF,
    parameter int unsigned PRE_TIMEOUT   = PRE_TIMEOUT_DEF,
    parameter int unsigned MAX_FRAME_CYC = MAX_FRAME_CYC_DEF
) (
    input  logic             i_aclk,
    input  logic             i_areset,
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_grant,
    output logic             o_src_start,
    output logic             o_preamble_sfd_tx_start,
    input  logic             i_preamble_sfd_tx_done,
    input  logic             i_tx_frame_done,
    output logic             o_tx_en,
    output logic             o_busy,
    output logic             o_err,
    output logic [15:0]      o_frame_cnt
);

    localparam int unsigned PTR_W = $clog2(N_REQ);
    localparam int unsigned TMR_W = $clog2(MAX_FRAME_CYC + 1);

    state_t           r_state, w_state_nxt;
    logic [TMR_W-1:0] r_timer, w_timer_nxt;
    logic [PTR_W-1:0] r_ptr, w_ptr_nxt, w_arb_idx;
    logic [N_REQ-1:0] r_grant, w_grant_nxt, w_arb_grant;
    logic             r_start, w_start_nxt;
    logic             r_tx_en, w_tx_en_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_err, w_err_nxt;
    logic [15:0]      r_frame_cnt, w_frame_cnt_nxt;
    logic             w_pre_to, w_max_to, w_ifg_to, w_abort;

    eth_tx_scheduler_rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx)
    );

    // Timer counts 0.. in each state; the last legal cycle is LIMIT-1.
    assign w_pre_to = (r_timer == TMR_W'(PRE_TIMEOUT - 1));
    assign w_max_to = (r_timer == TMR_W'(MAX_FRAME_CYC - 1));
    assign w_ifg_to = (r_timer == TMR_W'(IFG_CYC - 1));
    assign w_abort  = ((r_state == S_PREAMBLE) && !i_preamble_sfd_tx_done && w_pre_to) ||
                      ((r_state == S_PAYLOAD)  && !i_tx_frame_done        && w_max_to);

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_ptr       <= PTR_W'(N_REQ - 1);
            r_grant     <= '0;
            r_start     <= 1'b0;
            r_tx_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_ptr       <= w_ptr_nxt;
            r_grant     <= w_grant_nxt;
            r_start     <= w_start_nxt;
            r_tx_en     <= w_tx_en_nxt;
            r_busy      <= w_busy_nxt;
            r_err       <= w_err_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:     if (|i_req) w_state_nxt = S_PREAMBLE;
            S_PREAMBLE: if (i_preamble_sfd_tx_done) w_state_nxt = S_PAYLOAD;
                        else if (w_abort)           w_state_nxt = S_IFG;
            S_PAYLOAD:  if (i_tx_frame_done || w_abort) w_state_nxt = S_IFG;
            S_IFG:      if (w_ifg_to) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Next values for the registered outputs; pointer moves at grant time even if the frame aborts.
    always_comb begin
        w_ptr_nxt       = r_ptr;
        w_grant_nxt     = r_grant;
        w_start_nxt     = 1'b0;
        w_tx_en_nxt     = 1'b0;
        w_err_nxt       = w_abort;
        w_frame_cnt_nxt = r_frame_cnt;
        w_busy_nxt      = (w_state_nxt != S_IDLE);
        w_timer_nxt     = (w_state_nxt != r_state || r_state == S_IDLE) ? '0 : r_timer + TMR_W'(1);
        unique case (r_state)
            S_IDLE: begin
                if (|i_req) begin
                    w_grant_nxt = w_arb_grant;
                    w_ptr_nxt   = w_arb_idx;
                    w_start_nxt = 1'b1;
                end
            end
            S_PREAMBLE: begin
                w_tx_en_nxt = !w_abort;
                if (w_abort) w_grant_nxt = '0;
            end
            S_PAYLOAD: begin
                if (i_tx_frame_done) begin
                    w_grant_nxt     = '0;
                    w_frame_cnt_nxt = r_frame_cnt + 16'd1;
                end else if (w_abort) begin
                    w_grant_nxt = '0;
                end else begin
                    w_tx_en_nxt = 1'b1;
                end
            end
            default: w_grant_nxt = '0;
        endcase
    end

    assign o_grant                 = r_grant;
    assign o_preamble_sfd_tx_start = r_start;
    assign o_tx_en                 = r_tx_en;
    assign o_busy                  = r_busy;
    assign o_err                   = r_err;
    assign o_frame_cnt             = r_frame_cnt;
    assign o_src_start             = (r_state == S_PREAMBLE) && i_preamble_sfd_tx_done;

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Directed self-checking bench for eth_tx_scheduler: table of frames plus stall, runaway and reset sequences.
module tb_eth_tx_scheduler;

    localparam int unsigned N_REQ         = 2;
    localparam int unsigned IFG_CYC       = 12;
    localparam int unsigned PRE_TIMEOUT   = 15;
    localparam int unsigned MAX_FRAME_CYC = 1530;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  grant;
    logic        src_start, pst_start, pst_done, frame_done, tx_en, busy, err;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    eth_tx_scheduler #(
        .N_REQ         (N_REQ),
        .IFG_CYC       (IFG_CYC),
        .PRE_TIMEOUT   (PRE_TIMEOUT),
        .MAX_FRAME_CYC (MAX_FRAME_CYC)
    ) dut (
        .i_aclk                  (clk),
        .i_areset                (rst),
        .i_req                   (req),
        .o_grant                 (grant),
        .o_src_start             (src_start),
        .o_preamble_sfd_tx_start (pst_start),
        .i_preamble_sfd_tx_done  (pst_done),
        .i_tx_frame_done         (frame_done),
        .o_tx_en                 (tx_en),
        .o_busy                  (busy),
        .o_err                   (err),
        .o_frame_cnt             (frame_cnt)
    );

    typedef struct {
        logic [1:0]  req;
        int          pre_dly;
        int          pay_len;
        logic [1:0]  exp_grant;
        logic [15:0] exp_cnt;
        bit          spur;
    } vec_t;

    vec_t vecs[7];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64; i++) begin
            if (!busy) break;
            tick();
        end
        check("idle_wait", 32'(busy), 32'(1'b0));
    endtask

    // Called on a negedge in IDLE; returns on the first IDLE negedge after the IFG.
    task automatic do_frame(input vec_t v);
        int ok;
        req = v.req;
        tick();
        check("grant", 32'(grant), 32'(v.exp_grant));
        check("pst_start_t1", 32'(pst_start), 32'(1'b1));
        check("busy_t1", 32'(busy), 32'(1'b1));
        check("tx_en_t1", 32'(tx_en), 32'(1'b0));
        req = '0;
        if (v.pre_dly > 0) check("src_start_idle_pre", 32'(src_start), 32'(1'b0));
        if (v.spur) frame_done = 1'b1;
        for (int i = 0; i < v.pre_dly; i++) begin
            tick();
            frame_done = 1'b0;
            if (i == 0) begin
                check("pst_start_t2", 32'(pst_start), 32'(1'b0));
                check("tx_en_t2", 32'(tx_en), 32'(1'b1));
                if (v.spur) begin
                    check("spur_fd_grant", 32'(grant), 32'(v.exp_grant));
                    check("spur_fd_cnt", 32'(frame_cnt), 32'(v.exp_cnt - 16'd1));
                end
            end
        end
        pst_done = 1'b1;
        #1;
        check("src_start_sfd", 32'(src_start), 32'(1'b1));
        tick();
        pst_done = 1'b0;
        for (int i = 0; i < v.pay_len - 1; i++) tick();
        frame_done = 1'b1;
        #1;
        check("tx_en_last", 32'(tx_en), 32'(1'b1));
        check("cnt_before", 32'(frame_cnt), 32'(v.exp_cnt - 16'd1));
        tick();
        frame_done = 1'b0;
        check("grant_cleared", 32'(grant), 32'(2'b00));
        check("tx_en_fall", 32'(tx_en), 32'(1'b0));
        check("frame_cnt", 32'(frame_cnt), 32'(v.exp_cnt));
        check("err_quiet", 32'(err), 32'(1'b0));
        ok = 0;
        for (int k = 0; k < int'(IFG_CYC); k++) begin
            if (busy && !tx_en && grant == 2'b00) ok++;
            if (v.spur && k == 0) begin
                pst_done = 1'b1;
                #1;
                check("spur_sfd_ifg", 32'(src_start), 32'(1'b0));
            end
            tick();
            pst_done = 1'b0;
        end
        check("ifg_cycles", 32'(ok), IFG_CYC);
        check("busy_low_after_ifg", 32'(busy), 32'(1'b0));
        if (v.spur) begin
            pst_done   = 1'b1;
            frame_done = 1'b1;
            #1;
            check("spur_idle_src_start", 32'(src_start), 32'(1'b0));
            tick();
            pst_done   = 1'b0;
            frame_done = 1'b0;
            check("spur_idle_busy", 32'(busy), 32'(1'b0));
            check("spur_idle_cnt", 32'(frame_cnt), 32'(v.exp_cnt));
        end
    endtask

    initial begin
        int bad;
        vecs[0] = '{2'b01, 3, 5, 2'b01, 16'd1, 1'b1};
        vecs[1] = '{2'b11, 2, 4, 2'b10, 16'd2, 1'b0};
        vecs[2] = '{2'b11, 1, 2, 2'b01, 16'd3, 1'b0};
        vecs[3] = '{2'b11, 4, 3, 2'b10, 16'd4, 1'b1};
        vecs[4] = '{2'b10, 1, 2, 2'b10, 16'd5, 1'b0};
        vecs[5] = '{2'b01, 0, 1, 2'b01, 16'd6, 1'b0};
        vecs[6] = '{2'b11, 14, 2, 2'b10, 16'd7, 1'b0};

        rst = 1'b1; req = '0; pst_done = 1'b0; frame_done = 1'b0;
        tick(); tick();
        check("rst_grant", 32'(grant), 32'(2'b00));
        check("rst_busy", 32'(busy), 32'(1'b0));
        check("rst_tx_en", 32'(tx_en), 32'(1'b0));
        check("rst_start", 32'(pst_start), 32'(1'b0));
        check("rst_err", 32'(err), 32'(1'b0));
        check("rst_cnt", 32'(frame_cnt), 32'(16'd0));
        rst = 1'b0;
        tick();

        foreach (vecs[i]) do_frame(vecs[i]);

        // Preamble stall: SFD never arrives
        req = 2'b11;
        tick();
        check("stall_grant", 32'(grant), 32'(2'b01));
        req = '0;
        for (int k = 1; k < int'(PRE_TIMEOUT); k++) tick();
        check("stall_err_early", 32'(err), 32'(1'b0));
        check("stall_tx_en_pre", 32'(tx_en), 32'(1'b1));
        tick();
        check("stall_err", 32'(err), 32'(1'b1));
        check("stall_grant_clr", 32'(grant), 32'(2'b00));
        check("stall_tx_en", 32'(tx_en), 32'(1'b0));
        check("stall_busy", 32'(busy), 32'(1'b1));
        check("stall_cnt", 32'(frame_cnt), 32'(16'd7));
        tick();
        check("stall_err_pulse", 32'(err), 32'(1'b0));
        wait_idle();

        // Runaway payload: no FCS done, next grant goes to the other source
        req = 2'b11;
        tick();
        check("run_grant", 32'(grant), 32'(2'b10));
        req = '0;
        pst_done = 1'b1;
        tick();
        pst_done = 1'b0;
        bad = 0;
        for (int k = 0; k < int'(MAX_FRAME_CYC) - 1; k++) begin
            if (err || !tx_en) bad++;
            tick();
        end
        check("run_body", 32'(bad), 32'(0));
        check("run_err_early", 32'(err), 32'(1'b0));
        check("run_tx_en_last", 32'(tx_en), 32'(1'b1));
        tick();
        check("run_err", 32'(err), 32'(1'b1));
        check("run_tx_en", 32'(tx_en), 32'(1'b0));
        check("run_grant_clr", 32'(grant), 32'(2'b00));
        check("run_cnt", 32'(frame_cnt), 32'(16'd7));
        wait_idle();

        // Reset mid-payload after granting source 0
        req = 2'b01;
        tick();
        check("pre_rst_grant", 32'(grant), 32'(2'b01));
        req = '0;
        pst_done = 1'b1;
        tick();
        pst_done = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        check("mid_rst_grant", 32'(grant), 32'(2'b00));
        check("mid_rst_tx_en", 32'(tx_en), 32'(1'b0));
        check("mid_rst_busy", 32'(busy), 32'(1'b0));
        check("mid_rst_err", 32'(err), 32'(1'b0));
        check("mid_rst_cnt", 32'(frame_cnt), 32'(16'd0));
        check("mid_rst_start", 32'(pst_start), 32'(1'b0));
        tick();
        check("mid_rst_err_hold", 32'(err), 32'(1'b0));
        rst = 1'b0;
        tick();
        do_frame('{2'b11, 1, 3, 2'b01, 16'd1, 1'b0});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/eth_tx_scheduler.md
# eth_tx_scheduler

Sequences the Ethernet TX path for one frame at a time and shares it between `N_REQ` frame sources (e.g. ARP responder, UDP TX) with round-robin arbitration. Starts the preamble/SFD generator, hands the byte stream to the granted source after SFD, waits for the FCS stage to report end of frame, then enforces the inter-frame gap. Provides `tx_en` for the GMII stage and a watchdog that aborts stalled frames.

## Interface
- `N_REQ`, 2, number of frame sources (2..8)
- `IFG_CYC`, 12, idle cycles after each frame
- `PRE_TIMEOUT`, 15, max cycles from `preamble_sfd_tx_start` to `preamble_sfd_tx_done`
- `MAX_FRAME_CYC`, 1530, max payload+FCS cycles before abort
- `aclk` in 1: single clock; all logic on rising edge
- `areset` in 1: asynchronous, active-high reset
- `req` in N_REQ: per-source frame request, level, held until granted
- `grant` out N_REQ: one-hot owner of TX path
- `src_start` out 1: payload start strobe to granted source
- `preamble_sfd_tx_start` out 1: start pulse to preamble/SFD generator
- `preamble_sfd_tx_done` in 1: generator pulse, high in SFD byte cycle
- `tx_frame_done` in 1: FCS stage pulse, high in last FCS byte cycle
- `tx_en` out 1: frame-in-progress qualifier for GMII
- `busy` out 1: high in any state other than IDLE
- `err` out 1: one-cycle pulse on watchdog abort
- `frame_cnt` out 16: completed frames, wraps 0xFFFF→0

## Operation
- States: IDLE, PREAMBLE, PAYLOAD, IFG.
- IDLE: if `req` non-zero, register one-hot `grant` via round-robin (first requester after last grantee, circular), pulse `preamble_sfd_tx_start` one cycle, go PREAMBLE. Grant-time `req` decides; later `req` changes are ignored until IDLE.
- PREAMBLE: `src_start` = `preamble_sfd_tx_done` in this state (combinational, same cycle as SFD byte); on done go PAYLOAD. Source drives first payload byte the following cycle. If timer reaches `PRE_TIMEOUT` without done: abort.
- PAYLOAD: on `tx_frame_done` increment `frame_cnt`, clear `grant`, go IFG. If timer reaches `MAX_FRAME_CYC`: abort.
- IFG: count `IFG_CYC` cycles, then IDLE.
- Abort: `err` pulse, `grant` cleared, `tx_en` cleared, round-robin pointer still advances past aborted source, `frame_cnt` unchanged, go IFG.
- Round-robin pointer updates at grant time.
- Ignored inputs: `preamble_sfd_tx_done` outside PREAMBLE; `tx_frame_done` outside PAYLOAD.
- Single shared timer, width clog2(MAX_FRAME_CYC+1), cleared on every state change.

## Timing
- Reset values: `grant`=0, `src_start`=0, `preamble_sfd_tx_start`=0, `tx_en`=0, `busy`=0, `err`=0, `frame_cnt`=0, state IDLE, pointer = N_REQ-1 (source 0 wins first).
- Reset mid-frame: all outputs return to reset values immediately (async), no `err`.
- Cycle T: `req` seen in IDLE. T+1: `grant`, `preamble_sfd_tx_start`, `busy` high. T+2: `tx_en` high (matches first preamble byte), start low.
- `tx_en` falls in the cycle after `tx_frame_done` or abort decision.
- IFG: exactly `IFG_CYC` cycles with `busy`=1, `tx_en`=0; earliest next `preamble_sfd_tx_start` is `IFG_CYC`+2 cycles after `tx_frame_done`.
- All outputs except `src_start` are registered.

## Structure
- `eth_pkg`: state enum type, default IFG/timeout constants, 0x55/0xD5 preamble/SFD constants shared with the generator.
- Sub-module `rr_arbiter` (parameter N_REQ): `req`, pointer in, one-hot grant out, combinational; pointer register stays in scheduler.

## Test plan
- Single source: `req`=01 → `grant`=01 at T+1, start pulse 1 cycle, `src_start` coincident with done, `frame_cnt`=1, `busy` low `IFG_CYC`+1 cycles after `tx_frame_done`.
- Contention: `req`=11 held for 3 frames → grants 01,10,01; each separated by ≥12 idle `tx_en` cycles.
- Preamble stall: done never asserted → `err` pulse 15 cycles after start, `grant`=0, `frame_cnt` unchanged, next grant to other source.
- Runaway payload: no `tx_frame_done` → abort after 1530 PAYLOAD cycles, `tx_en` low next cycle.
- Spurious inputs: `tx_frame_done` in PREAMBLE, `preamble_sfd_tx_done` in IDLE/IFG → no state change, no count.
- Reset asserted mid-PAYLOAD → all outputs 0 same cycle; after release, source 0 wins first.
